// File: rtl/bcd_convert_arbiter_if.sv
// Request/response bundle between stopwatch requesters and the shared BCD engine.
// The master side is the requester/display side; the slave side is the engine.
interface bcd_convert_arbiter_if #(
    parameter int NUM_REQ = 3
) ();
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_bin;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 rsp_valid;
    logic [ID_W-1:0]      rsp_id;
    logic [11:0]          rsp_bcd;
    logic                 busy;

    modport master (
        output req_valid,
        output req_bin,
        input  req_ready,
        input  rsp_valid,
        input  rsp_id,
        input  rsp_bcd,
        input  busy
    );

    modport slave (
        input  req_valid,
        input  req_bin,
        output req_ready,
        output rsp_valid,
        output rsp_id,
        output rsp_bcd,
        output busy
    );
endinterface

// File: rtl/bcd_convert_arbiter.sv
// Round-robin shared 8-bit binary to 3-digit BCD converter (double dabble, 1 bit/cycle).
// One conversion every 10 cycles: accept in IDLE, 8 CONVERT cycles, one DONE cycle.
module bcd_convert_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    bcd_convert_arbiter_if.slave       bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [ID_W-1:0] last_grant_reg, last_grant_next;
    logic [7:0]      shift_reg, shift_next;
    logic [11:0]     acc_reg, acc_next;
    logic [2:0]      cnt_reg, cnt_next;
    logic [ID_W-1:0] id_reg, id_next;
    logic [11:0]     rsp_bcd_reg, rsp_bcd_next;
    logic [ID_W-1:0] rsp_id_reg, rsp_id_next;

    logic [ID_W-1:0]    cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_valid;
    logic [7:0]         bin_arr [NUM_REQ];
    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [NUM_REQ-1:0] ready_w;
    logic [7:0]         grant_bin;
    logic [11:0]        acc_adj;
    logic [11:0]        acc_step;
    logic [7:0]         shift_step;

    // Search order starts just after the last winner: candidate gi is
    // (last_grant + 1 + gi) mod NUM_REQ, so lower gi means higher priority.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [ID_W:0] sum;
        assign sum = {1'b0, last_grant_reg} + (ID_W+1)'(gi + 1);
        assign cand_idx[gi]   = (sum >= (ID_W+1)'(NUM_REQ))
                              ? ID_W'(sum - (ID_W+1)'(NUM_REQ))
                              : sum[ID_W-1:0];
        assign cand_valid[gi] = bus.req_valid[cand_idx[gi]];
        assign bin_arr[gi]    = bus.req_bin[8*gi +: 8];
    end

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand_valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx[i];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
        assign ready_w[gi] = (state_reg == IDLE) && grant_found
                           && (grant_idx == ID_W'(gi));
    end

    always_comb begin
        grant_bin = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (ready_w[j]) begin
                grant_bin = bin_arr[j];
            end
        end
    end

    // Add-3 correction on each digit before the shift; nibbles are independent.
    for (genvar gi = 0; gi < 3; gi++) begin : g_dabble
        assign acc_adj[4*gi +: 4] = (acc_reg[4*gi +: 4] >= 4'd5)
                                  ? acc_reg[4*gi +: 4] + 4'd3
                                  : acc_reg[4*gi +: 4];
    end

    assign acc_step   = (acc_adj << 1) | 12'(shift_reg[7]);
    assign shift_step = shift_reg << 1;

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        shift_next      = shift_reg;
        acc_next        = acc_reg;
        cnt_next        = cnt_reg;
        id_next         = id_reg;
        rsp_bcd_next    = rsp_bcd_reg;
        rsp_id_next     = rsp_id_reg;
        case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    last_grant_next = grant_idx;
                    shift_next      = grant_bin;
                    id_next         = grant_idx;
                    acc_next        = '0;
                    cnt_next        = '0;
                    state_next      = CONVERT;
                end
            end
            CONVERT: begin
                acc_next   = acc_step;
                shift_next = shift_step;
                cnt_next   = cnt_reg + 3'd1;
                // Result is captured on the final shift so it is already
                // registered when rsp_valid rises in DONE.
                if (cnt_reg == 3'd7) begin
                    rsp_bcd_next = acc_step;
                    rsp_id_next  = id_reg;
                    state_next   = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= ID_W'(NUM_REQ - 1);
            shift_reg      <= '0;
            acc_reg        <= '0;
            cnt_reg        <= '0;
            id_reg         <= '0;
            rsp_bcd_reg    <= '0;
            rsp_id_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            shift_reg      <= shift_next;
            acc_reg        <= acc_next;
            cnt_reg        <= cnt_next;
            id_reg         <= id_next;
            rsp_bcd_reg    <= rsp_bcd_next;
            rsp_id_reg     <= rsp_id_next;
        end
    end

    assign bus.req_ready = ready_w;
    assign bus.rsp_valid = (state_reg == DONE);
    assign bus.rsp_bcd   = rsp_bcd_reg;
    assign bus.rsp_id    = rsp_id_reg;
    assign bus.busy      = (state_reg != IDLE);

endmodule
